fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/riscv_core_pkg.sv | 22 ++
 rtl/fetch_buffer.sv | 78 +++++++
 rtl/fetch_stage.sv | 136 +++++++++++++
 3 files changed

// File: rtl/riscv_core_pkg.sv
// -----------------------------------------------------------------------------
// riscv_core_pkg
//   Shared types and constants for the core front end.
//   FETCH_DEPTH    : instructions that may be buffered or in flight in Fetch
//   fetch_state_e  : fetch control FSM states (run / drain stale responses)
//   fetch_entry_t  : one IF/ID buffer entry {pc, instr}
// -----------------------------------------------------------------------------
package riscv_core_pkg;

  localparam int FETCH_DEPTH = 2;

  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//   Small in-order FIFO of fetched {pc, instr} entries.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write push_data_i at the tail (ignored when full)
//   pop_i         : drop the head entry (ignored when empty)
//   clear_i       : empty the FIFO; wins over push and pop
//   full_o/empty_o: occupancy flags, count_o: number of entries held
//   head_o        : oldest entry, all-zero while empty
// -----------------------------------------------------------------------------
module fetch_buffer
  import riscv_core_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  fetch_entry_t                 push_data_i,
  input  logic                         pop_i,
  input  logic                         clear_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output fetch_entry_t                 head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // NOTE: storage is deliberately not reset; the pointers and count define
  // what is valid, and head_o is forced to zero while nothing is held.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch: issues in-order reads, buffers responses for decode,
//   and discards stale responses after a flush or redirect.
//   clk_i, rst_ni                       : clock, asynchronous active-low reset
//   stall_f_i                           : decode does not take IF/ID this cycle
//   flush_f_i                           : drop buffered and in-flight fetches
//   pc_redirect_i, pc_redirect_target_i : taken branch/jump from Execute
//   i_arvalid_o, i_araddr_o, i_arready_i: instruction read request channel
//   i_rvalid_i, i_rdata_i               : in-order read response channel
//   if_id_valid_o, if_id_pc_o, if_id_instr_o : IF/ID slot (FIFO head)
// -----------------------------------------------------------------------------
module fetch_stage
  import riscv_core_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_f_i,
  input  logic        flush_f_i,
  input  logic        pc_redirect_i,
  input  logic [31:0] pc_redirect_target_i,
  output logic        i_arvalid_o,
  output logic [31:0] i_araddr_o,
  input  logic        i_arready_i,
  input  logic        i_rvalid_i,
  input  logic [31:0] i_rdata_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_instr_o
);

  localparam int CNT_W = $clog2(FETCH_DEPTH + 1);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [1:0]       live_q, live_d;        // accepted requests whose data will be kept
  logic [1:0]       discard_q, discard_d;  // responses still to be thrown away
  logic             active_q;              // holds off issue until the first edge out of reset
  logic             kill, pop, accept, push, credit_ok;
  logic [1:0]       inflight_sum;
  logic [CNT_W-1:0] buf_count;
  logic             buf_full, buf_empty;
  fetch_entry_t     push_entry, head_entry;

  assign kill   = flush_f_i | pc_redirect_i;
  assign pop    = if_id_valid_o & ~stall_f_i;
  assign accept = i_arvalid_o & i_arready_i;

  // Credit counts the head as free when decode takes it this cycle; without
  // that, a 1-cycle memory could only deliver every other cycle.
  assign credit_ok = ({1'b0, live_q} + 3'(buf_count)) < (3'(FETCH_DEPTH) + {2'b0, pop});

  // No issue while stale responses are pending, so live and stale requests
  // never interleave and the discard count stays within two bits.
  assign i_arvalid_o = active_q & (state_q == FETCH_RUN) & credit_ok;
  assign i_araddr_o  = pc_q;

  // Live requests are consecutive and end at pc_q - 4, so the oldest one
  // (the one answering now) was issued from pc_q - 4*live_q.
  assign push_entry.pc    = pc_q - {28'b0, live_q, 2'b00};
  assign push_entry.instr = i_rdata_i;

  // Guard keeps a full buffer from being overwritten should the memory ever
  // answer beyond the granted credit.
  assign push = i_rvalid_i & (state_q == FETCH_RUN) & ~kill & ~(buf_full & ~pop);

  // Everything still owed by memory after this edge; never exceeds two.
  assign inflight_sum = discard_q + live_q + 2'(accept) - 2'(i_rvalid_i);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    live_d    = live_q;
    discard_d = discard_q;
    if (kill) begin
      live_d    = '0;
      discard_d = inflight_sum;
      state_d   = (inflight_sum != '0) ? FETCH_DRAIN : FETCH_RUN;
      if (pc_redirect_i) pc_d = pc_redirect_target_i;
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      unique case (state_q)
        FETCH_RUN: begin
          live_d = live_q + 2'(accept) - 2'(i_rvalid_i);
        end
        FETCH_DRAIN: begin
          if (i_rvalid_i) begin
            discard_d = discard_q - 2'd1;
            if (discard_q == 2'd1) state_d = FETCH_RUN;
          end
        end
        default: state_d = FETCH_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= FETCH_RUN;
      pc_q      <= RESET_VECTOR;
      live_q    <= '0;
      discard_q <= '0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      live_q    <= live_d;
      discard_q <= discard_d;
      active_q  <= 1'b1;
    end
  end

  fetch_buffer #(
    .DEPTH (FETCH_DEPTH)
  ) u_fetch_buffer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .clear_i     (kill),
    .full_o      (buf_full),
    .empty_o     (buf_empty),
    .count_o     (buf_count),
    .head_o      (head_entry)
  );

  assign if_id_valid_o = ~buf_empty;
  assign if_id_pc_o    = head_entry.pc;
  assign if_id_instr_o = head_entry.instr;

endmodule
